// File: rtl/lcd_dbg_display.sv
// rtl/lcd_dbg_display.sv - HD44780 4-bit LCD driver showing a text line and a labelled hex debug word
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   line0_text   in   8*COLS bits, ASCII for line 0, MSB byte = leftmost character
//   label        in   8*LBL_CHARS bits, ASCII label for line 1, MSB byte = leftmost
//   data         in   DATA_W bits, debug word rendered as DATA_W/4 hex digits on line 1
//   busy         out  high while init or a redraw is in progress
//   lcd_e        out  LCD enable strobe
//   lcd_rs       out  0 = command, 1 = data
//   lcd_rw       out  tied 0
//   lcd_dat      out  LCD data nibble DB7..DB4
//
// Optional feature macro: LCD_ZERO_BLANK_EN (leading zero hex digits render as spaces).

module lcd_dbg_display #(
    parameter int COLS      = 16,
    parameter int DATA_W    = 32,
    parameter int LBL_CHARS = 7,
    parameter int PWRON_CYC = 750000,
    parameter int E_CYC     = 12,
    parameter int NIB_GAP   = 50,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 82000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*COLS-1:0]      line0_text,
    input  logic [8*LBL_CHARS-1:0] label,
    input  logic [DATA_W-1:0]      data,
    output logic                   busy,
    output logic                   lcd_e,
    output logic                   lcd_rs,
    output logic                   lcd_rw,
    output logic [3:0]             lcd_dat
);

    localparam int NDIG     = DATA_W / 4;
    localparam int DIG0     = COLS - NDIG;
    localparam int IN_W     = 8*COLS + 8*LBL_CHARS + DATA_W;
    localparam int MAX_A    = (PWRON_CYC > CLR_CYC) ? PWRON_CYC : CLR_CYC;
    localparam int MAX_B    = (CMD_CYC > NIB_GAP) ? CMD_CYC : NIB_GAP;
    localparam int MAX_C    = (MAX_B > E_CYC) ? MAX_B : E_CYC;
    localparam int MAX_WAIT = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW       = $clog2(MAX_WAIT + 1);
    localparam int IW       = $clog2(COLS);

    localparam logic [CW-1:0] PWRON_LAST = CW'(PWRON_CYC - 1);
    localparam logic [CW-1:0] E_LAST     = CW'(E_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(NIB_GAP - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);
    localparam logic [IW-1:0] COL_LAST   = IW'(COLS - 1);
    localparam logic [IW-1:0] INIT_LAST  = IW'(3);

    typedef enum logic [2:0] {
        S_PWRON, S_INIT8, S_INITB, S_IDLE, S_SNAP, S_ADDR, S_CHAR
    } state_t;

    // Nibble writer phases: SETUP drives rs/dat one cycle ahead of lcd_e,
    // EHI holds lcd_e, GAP separates the two nibbles, WAIT is the command delay.
    typedef enum logic [2:0] {
        W_IDLE, W_SETUP, W_EHI, W_GAP, W_WAIT
    } wr_t;

    state_t                state_q;
    wr_t                   wr_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic                  line_q;
    logic [3:0]            wr_lo_nib_q;
    logic                  wr_lo_q;
    logic                  wr_clr_q;
    logic                  lcd_e_q;
    logic                  lcd_rs_q;
    logic [3:0]            lcd_dat_q;

    logic [IN_W-1:0]       in_q;
    logic [IN_W-1:0]       in_prev_q;
    logic                  pending_q;
    logic [8*COLS-1:0]     line0_q;
    logic [8*COLS-1:0]     line1_q;

    logic [8*COLS-1:0]     in_line0;
    logic [8*LBL_CHARS-1:0] in_label;
    logic [DATA_W-1:0]     in_data;
    logic [8*COLS-1:0]     line1_d;
    logic [3:0]            nib;
    logic                  changed;
    logic                  enter_snap;
    logic [7:0]            cur_byte;
    logic                  cur_rs;
    logic                  cur_single;
    logic                  send_req;
    int                    col_sh;
`ifdef LCD_ZERO_BLANK_EN
    logic                  lead;
`endif

    assign in_line0 = in_q[IN_W-1 -: 8*COLS];
    assign in_label = in_q[DATA_W +: 8*LBL_CHARS];
    assign in_data  = in_q[DATA_W-1:0];

    assign changed    = (in_q != in_prev_q);
    assign enter_snap = (state_q == S_IDLE) && pending_q;

    assign busy    = !((state_q == S_IDLE) && !pending_q);
    assign lcd_e   = lcd_e_q;
    assign lcd_rs  = lcd_rs_q;
    assign lcd_rw  = 1'b0;
    assign lcd_dat = lcd_dat_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Input registration and change detect; a change on the same cycle as
    // SNAP entry keeps pending set so the newer value gets its own redraw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q      <= '0;
            in_prev_q <= '0;
            pending_q <= 1'b1;
        end else begin
            in_q      <= {line0_text, label, data};
            in_prev_q <= in_q;
            if (changed) begin
                pending_q <= 1'b1;
            end else if (enter_snap) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Line-1 rendering: label, space fill, then right-justified hex digits.
    always_comb begin
        line1_d = '0;
        nib     = '0;
`ifdef LCD_ZERO_BLANK_EN
        lead    = 1'b1;
`endif
        for (int c = 0; c < LBL_CHARS; c++) begin
            line1_d[8*(COLS-1-c) +: 8] = in_label[8*(LBL_CHARS-1-c) +: 8];
        end
        for (int c = LBL_CHARS; c < DIG0; c++) begin
            line1_d[8*(COLS-1-c) +: 8] = 8'h20;
        end
        for (int k = 0; k < NDIG; k++) begin
            nib = in_data[4*(NDIG-1-k) +: 4];
            line1_d[8*(NDIG-1-k) +: 8] = hex_ascii(nib);
`ifdef LCD_ZERO_BLANK_EN
            if (nib != 4'h0) begin
                lead = 1'b0;
            end
            // The least-significant digit is never blanked so zero shows "0".
            if (lead && (k != NDIG-1)) begin
                line1_d[8*(NDIG-1-k) +: 8] = 8'h20;
            end
`endif
        end
    end

    // Frame snapshot: the redraw in flight always reads from these registers,
    // so input changes during a redraw cannot tear the displayed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line0_q <= '0;
            line1_q <= '0;
        end else if (state_q == S_SNAP) begin
            line0_q <= in_line0;
            line1_q <= line1_d;
        end
    end

    // Byte the current state wants to send next.
    always_comb begin
        cur_byte   = 8'h00;
        cur_rs     = 1'b0;
        cur_single = 1'b0;
        send_req   = 1'b0;
        col_sh     = 0;
        case (state_q)
            S_INIT8: begin
                send_req   = 1'b1;
                cur_single = 1'b1;
                cur_byte   = (idx_q == INIT_LAST) ? 8'h02 : 8'h03;
            end
            S_INITB: begin
                send_req = 1'b1;
                case (idx_q[1:0])
                    2'd0:    cur_byte = 8'h28;
                    2'd1:    cur_byte = 8'h0C;
                    2'd2:    cur_byte = 8'h06;
                    default: cur_byte = 8'h01;
                endcase
            end
            S_ADDR: begin
                send_req = 1'b1;
                cur_byte = line_q ? 8'hC0 : 8'h80;
            end
            S_CHAR: begin
                send_req = 1'b1;
                cur_rs   = 1'b1;
                col_sh   = 8 * (COLS - 1 - int'(idx_q));
                cur_byte = line_q ? line1_q[col_sh +: 8] : line0_q[col_sh +: 8];
            end
            default: ;
        endcase
    end

    // Main sequencer and nibble writer. The main state only advances when the
    // writer returns to W_IDLE after the post-byte wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRON;
            wr_q        <= W_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            line_q      <= 1'b0;
            wr_lo_nib_q <= '0;
            wr_lo_q     <= 1'b0;
            wr_clr_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_dat_q   <= '0;
        end else begin
            case (wr_q)
                W_IDLE: begin
                    if (state_q == S_PWRON) begin
                        if (cnt_q == PWRON_LAST) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= S_INIT8;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (state_q == S_IDLE) begin
                        if (pending_q) begin
                            state_q <= S_SNAP;
                        end
                    end else if (state_q == S_SNAP) begin
                        state_q <= S_ADDR;
                        line_q  <= 1'b0;
                        idx_q   <= '0;
                    end else if (send_req) begin
                        // Single init nibbles go straight to the post-byte wait.
                        wr_lo_nib_q <= cur_byte[3:0];
                        wr_lo_q     <= cur_single;
                        wr_clr_q    <= !cur_single && (cur_byte == 8'h01);
                        lcd_rs_q    <= cur_rs;
                        lcd_dat_q   <= cur_single ? cur_byte[3:0] : cur_byte[7:4];
                        wr_q        <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    lcd_e_q <= 1'b1;
                    cnt_q   <= '0;
                    wr_q    <= W_EHI;
                end
                W_EHI: begin
                    if (cnt_q == E_LAST) begin
                        lcd_e_q <= 1'b0;
                        cnt_q   <= '0;
                        wr_q    <= wr_lo_q ? W_WAIT : W_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                W_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q     <= '0;
                        lcd_dat_q <= wr_lo_nib_q;
                        wr_lo_q   <= 1'b1;
                        wr_q      <= W_SETUP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                W_WAIT: begin
                    if (cnt_q == (wr_clr_q ? CLR_LAST : CMD_LAST)) begin
                        cnt_q <= '0;
                        wr_q  <= W_IDLE;
                        case (state_q)
                            S_INIT8: begin
                                if (idx_q == INIT_LAST) begin
                                    state_q <= S_INITB;
                                    idx_q   <= '0;
                                end else begin
                                    idx_q <= idx_q + 1'b1;
                                end
                            end
                            S_INITB: begin
                                if (idx_q == INIT_LAST) begin
                                    state_q <= S_IDLE;
                                    idx_q   <= '0;
                                end else begin
                                    idx_q <= idx_q + 1'b1;
                                end
                            end
                            S_ADDR: begin
                                state_q <= S_CHAR;
                                idx_q   <= '0;
                            end
                            S_CHAR: begin
                                if (idx_q == COL_LAST) begin
                                    idx_q <= '0;
                                    if (line_q) begin
                                        line_q  <= 1'b0;
                                        state_q <= S_IDLE;
                                    end else begin
                                        line_q  <= 1'b1;
                                        state_q <= S_ADDR;
                                    end
                                end else begin
                                    idx_q <= idx_q + 1'b1;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: wr_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_dbg_display.sv
// tb/tb_lcd_dbg_display.sv - self-checking bench for lcd_dbg_display
module tb_lcd_dbg_display;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] line0_text;
    logic [55:0]  label;
    logic [31:0]  data;
    logic         busy, lcd_e, lcd_rs, lcd_rw;
    logic [3:0]   lcd_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int e_rises = 0;
    logic prev_e = 1'b0;
    logic [4:0] cap_q [$];

    always #5 clk = ~clk;

    lcd_dbg_display #(
        .COLS(16), .DATA_W(32), .LBL_CHARS(7),
        .PWRON_CYC(20), .E_CYC(2), .NIB_GAP(2), .CMD_CYC(4), .CLR_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line0_text(line0_text), .label(label), .data(data),
        .busy(busy), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_dat(lcd_dat)
    );

    // Record {rs, dat} on every falling edge of lcd_e, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && prev_e && !lcd_e) cap_q.push_back({lcd_rs, lcd_dat});
        if (rst_n && !prev_e && lcd_e) e_rises++;
        prev_e = lcd_e;
    end

    typedef struct {
        logic [127:0] line0;
        logic [55:0]  lbl;
        logic [31:0]  data;
        logic [127:0] exp1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(busy), 128'(lvl));
    endtask

    task automatic wait_caps(input int cnt, input int budget, input string name);
        int n = 0;
        while (cap_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(cap_q.size() >= cnt), 128'(1));
    endtask

    task automatic check_init(input string tag);
        logic [127:0] got, exp;
        logic [3:0] nb [12];
        nb = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        got = '0;
        exp = '0;
        chk({tag, " init count"}, 128'(cap_q.size() >= 12), 128'(1));
        if (cap_q.size() < 12) return;
        for (int i = 0; i < 12; i++) begin
            got = (got << 5) | 128'(cap_q.pop_front());
            exp = (exp << 5) | 128'({1'b0, nb[i]});
        end
        chk({tag, " init nibbles"}, got, exp);
    endtask

    task automatic check_frame(input string tag, input logic [127:0] exp0, input logic [127:0] exp1);
        logic [7:0]   b [34];
        logic [4:0]   hi, lo;
        logic [127:0] rs_got, rs_exp, got0, got1;
        rs_got = '0;
        rs_exp = '0;
        got0 = '0;
        got1 = '0;
        chk({tag, " frame count"}, 128'(cap_q.size() >= 68), 128'(1));
        if (cap_q.size() < 68) return;
        for (int i = 0; i < 34; i++) begin
            hi = cap_q.pop_front();
            lo = cap_q.pop_front();
            b[i] = {hi[3:0], lo[3:0]};
            rs_got = (rs_got << 2) | 128'({hi[4], lo[4]});
            rs_exp = (rs_exp << 2) | ((i == 0 || i == 17) ? 128'(0) : 128'(3));
        end
        for (int i = 1; i <= 16; i++) got0 = (got0 << 8) | 128'(b[i]);
        for (int i = 18; i <= 33; i++) got1 = (got1 << 8) | 128'(b[i]);
        chk({tag, " addr0"}, 128'(b[0]), 128'(8'h80));
        chk({tag, " line0"}, got0, exp0);
        chk({tag, " addr1"}, 128'(b[17]), 128'(8'hC0));
        chk({tag, " line1"}, got1, exp1);
        chk({tag, " rs"}, rs_got, rs_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] exp_mid, exp_rst;

        vecs[0] = '{"F00D01E02M03W04 ", "IF-ADDR", 32'h0040_00AC, "IF-ADDR 004000AC"};
        vecs[1] = '{"F00D01E02M03W04 ", "IF-ADDR", 32'h0000_00AC, "IF-ADDR 000000AC"};
        vecs[2] = '{"F00D01E02M03W04 ", "IF-ADDR", 32'h0000_0000, "IF-ADDR 00000000"};
        vecs[3] = '{"0123456789ABCDEF", "STATUS:", 32'hDEAD_BEEF, "STATUS: DEADBEEF"};
        vecs[4] = '{"hello, world!   ", "abcdefg", 32'h1234_5678, "abcdefg 12345678"};
        vecs[5] = '{"hello, world!   ", "abcdefg", 32'hF000_0000, "abcdefg F0000000"};
        exp_mid = "IF-ADDR 00000002";
        exp_rst = "IF-ADDR 00000003";
`ifdef LCD_ZERO_BLANK_EN
        vecs[0].exp1 = "IF-ADDR   4000AC";
        vecs[1].exp1 = "IF-ADDR       AC";
        vecs[2].exp1 = "IF-ADDR        0";
        exp_mid      = "IF-ADDR        2";
        exp_rst      = "IF-ADDR        3";
`endif

        rst_n = 1'b0;
        line0_text = '0;
        label = '0;
        data = '0;
        repeat (3) @(negedge clk);
        chk("reset lcd_e", 128'(lcd_e), 128'(0));
        chk("reset lcd_rs", 128'(lcd_rs), 128'(0));
        chk("reset lcd_rw", 128'(lcd_rw), 128'(0));
        chk("reset lcd_dat", 128'(lcd_dat), 128'(0));
        chk("reset busy", 128'(busy), 128'(1));

        for (int i = 0; i < 6; i++) begin
            line0_text = vecs[i].line0;
            label = vecs[i].lbl;
            data = vecs[i].data;
            if (i == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                wait_busy(1'b1, 20, $sformatf("v%0d busy rise", i));
            end
            wait_busy(1'b0, 5000, $sformatf("v%0d busy fall", i));
            if (i == 0) check_init("v0");
            check_frame($sformatf("v%0d", i), vecs[i].line0, vecs[i].exp1);
            chk($sformatf("v%0d leftover", i), 128'(cap_q.size()), 128'(0));
        end

        // Steady inputs: no strobes, busy stays low.
        begin
            int busy_hi = 0;
            e_rises = 0;
            repeat (1000) begin
                @(negedge clk);
                if (busy) busy_hi++;
            end
            chk("steady e pulses", 128'(e_rises), 128'(0));
            chk("steady busy", 128'(busy_hi), 128'(0));
        end

        // Two changes during line-1 characters collapse into one follow-up redraw.
        line0_text = vecs[0].line0;
        label = vecs[0].lbl;
        data = vecs[0].data;
        wait_busy(1'b1, 20, "mid busy rise");
        wait_caps(44, 3000, "mid reach line1");
        data = 32'h1;
        repeat (3) @(negedge clk);
        data = 32'h2;
        wait_busy(1'b0, 10000, "mid busy fall");
        check_frame("mid old", vecs[0].line0, vecs[0].exp1);
        check_frame("mid new", vecs[0].line0, exp_mid);
        repeat (200) @(negedge clk);
        chk("mid leftover", 128'(cap_q.size()), 128'(0));

        // Asynchronous reset while lcd_e is high during a character byte.
        data = 32'h3;
        wait_busy(1'b1, 20, "rst busy rise");
        wait_caps(8, 3000, "rst reach char");
        begin
            int n = 0;
            while (!(lcd_e && lcd_rs) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rst pre e&rs", 128'(lcd_e && lcd_rs), 128'(1));
        end
        rst_n = 1'b0;
        #1;
        chk("async lcd_e", 128'(lcd_e), 128'(0));
        chk("async lcd_rs", 128'(lcd_rs), 128'(0));
        chk("async lcd_dat", 128'(lcd_dat), 128'(0));
        chk("async busy", 128'(busy), 128'(1));
        repeat (3) @(negedge clk);
        cap_q.delete();
        rst_n = 1'b1;
        wait_busy(1'b0, 5000, "rst busy fall");
        check_init("rst");
        check_frame("rst", vecs[0].line0, exp_rst);
        chk("rst leftover", 128'(cap_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
